axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave.sv | 264 ++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI4 slave in front of a 2**DEPTH_LOG2 x 32-bit SRAM; the read and write paths are independent FSMs.
// Build option AXI_SRAM_RANGE_CHECK_EN: bursts that start beyond the memory get SLVERR (writes dropped, reads return 0).
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready high, waiting for an address
//   W_DATA | wready high, accepting awlen+1 beats
//   W_RESP | bvalid high until bready
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for an address
//   R_DATA | rvalid high, presenting arlen+1 beats

module axi_sram_slave #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef logic [DEPTH_LOG2-1:0] idx_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   function automatic idx_t next_idx(input idx_t cur, input logic fixed);
      return fixed ? cur : cur + idx_t'(1);
   endfunction

   logic [31:0] mem_q [DEPTH];

   w_state_t    w_state_q, w_state_d;
   idx_t        widx_q, widx_d;
   logic [7:0]  wcnt_q, wcnt_d;
   logic        wfixed_q, wfixed_d;
   logic        werr_q, werr_d;
   logic        awready_q, awready_d;
   logic        wready_q, wready_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        mem_we;

   r_state_t    r_state_q, r_state_d;
   idx_t        ridx_q, ridx_d;
   logic [7:0]  rcnt_q, rcnt_d;
   logic        rfixed_q, rfixed_d;
   logic        rerr_q, rerr_d;
   logic        arready_q, arready_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic        rlast_q, rlast_d;

   idx_t        aw_idx, ar_idx, rd_idx;
   logic [31:0] rd_word;
   logic        aw_oor, ar_oor;
   logic        unused_ok;

   assign aw_idx = awaddr[DEPTH_LOG2+1:2];
   assign ar_idx = araddr[DEPTH_LOG2+1:2];

`ifdef AXI_SRAM_RANGE_CHECK_EN
   assign aw_oor = (awaddr >> (DEPTH_LOG2 + 2)) != 32'd0;
   assign ar_oor = (araddr >> (DEPTH_LOG2 + 2)) != 32'd0;
`else
   assign aw_oor = 1'b0;
   assign ar_oor = 1'b0;
`endif

   // Transfer size, wlast and the byte offset carry no information for a fixed 32-bit beat.
   assign unused_ok = ^{awsize, arsize, wlast, awaddr, araddr};

   // Single read port: the AR address while idle, otherwise the next beat of the burst.
   assign rd_idx  = (r_state_q == R_IDLE) ? ar_idx : ridx_q;
   assign rd_word = mem_q[rd_idx];

   always_comb begin
      w_state_d = w_state_q;
      widx_d    = widx_q;
      wcnt_d    = wcnt_q;
      wfixed_d  = wfixed_q;
      werr_d    = werr_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      mem_we    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (awvalid && awready_q) begin
               w_state_d = W_DATA;
               widx_d    = aw_idx;
               wcnt_d    = awlen;
               wfixed_d  = (awburst == 2'b00);
               werr_d    = aw_oor;
            end
         end
         W_DATA: begin
            if (wvalid && wready_q) begin
               mem_we = !werr_q;
               if (wcnt_q == 8'd0) begin
                  w_state_d = W_RESP;
                  bvalid_d  = 1'b1;
                  bresp_d   = werr_q ? RESP_SLVERR : RESP_OKAY;
               end else begin
                  wcnt_d = wcnt_q - 8'd1;
                  widx_d = next_idx(widx_q, wfixed_q);
               end
            end
         end
         W_RESP: begin
            if (bvalid_q && bready) begin
               w_state_d = W_IDLE;
               bvalid_d  = 1'b0;
               bresp_d   = RESP_OKAY;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
   end

   always_comb begin
      r_state_d = r_state_q;
      ridx_d    = ridx_q;
      rcnt_d    = rcnt_q;
      rfixed_d  = rfixed_q;
      rerr_d    = rerr_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      case (r_state_q)
         R_IDLE: begin
            if (arvalid && arready_q) begin
               r_state_d = R_DATA;
               rfixed_d  = (arburst == 2'b00);
               ridx_d    = next_idx(ar_idx, arburst == 2'b00);
               rcnt_d    = arlen;
               rerr_d    = ar_oor;
               rvalid_d  = 1'b1;
               rdata_d   = ar_oor ? 32'd0 : rd_word;
               rresp_d   = ar_oor ? RESP_SLVERR : RESP_OKAY;
               rlast_d   = (arlen == 8'd0);
            end
         end
         R_DATA: begin
            if (rvalid_q && rready) begin
               if (rlast_q) begin
                  r_state_d = R_IDLE;
                  rvalid_d  = 1'b0;
                  rdata_d   = 32'd0;
                  rresp_d   = RESP_OKAY;
                  rlast_d   = 1'b0;
               end else begin
                  rdata_d = rerr_q ? 32'd0 : rd_word;
                  ridx_d  = next_idx(ridx_q, rfixed_q);
                  rcnt_d  = rcnt_q - 8'd1;
                  rlast_d = (rcnt_q == 8'd1);
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      arready_d = (r_state_d == R_IDLE);
   end

   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         w_state_q <= W_IDLE;
         widx_q    <= '0;
         wcnt_q    <= '0;
         wfixed_q  <= 1'b0;
         werr_q    <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         widx_q    <= widx_d;
         wcnt_q    <= wcnt_d;
         wfixed_q  <= wfixed_d;
         werr_q    <= werr_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         r_state_q <= R_IDLE;
         ridx_q    <= '0;
         rcnt_q    <= '0;
         rfixed_q  <= 1'b0;
         rerr_q    <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         rlast_q   <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         ridx_q    <= ridx_d;
         rcnt_q    <= rcnt_d;
         rfixed_q  <= rfixed_d;
         rerr_q    <= rerr_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
      end
   end

   // Array has no reset so contents survive areset; reads sample it at the same edge (old data wins).
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem_q[widx_q][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: behavioural memory/protocol model checked every cycle,
// plus directed scenarios with literal expectations and a randomized burst phase.

module tb_axi_sram_slave;

   localparam int DL2   = 10;
   localparam int DEPTH = 1 << DL2;

   logic        aclk = 1'b0;
   logic        areset = 1'b0;
   logic [31:0] awaddr = '0;
   logic [7:0]  awlen = '0;
   logic [2:0]  awsize = '0;
   logic [1:0]  awburst = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wlast = 1'b0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [31:0] araddr = '0;
   logic [7:0]  arlen = '0;
   logic [2:0]  arsize = '0;
   logic [1:0]  arburst = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready = 1'b0;

   axi_sram_slave #(.DEPTH_LOG2(DL2)) dut (
      .aclk(aclk), .areset(areset),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {logic [31:0] d; logic [1:0] r; logic l;} rbeat_t;

   logic [31:0] m_mem [DEPTH];
   int          wph = 0, rph = 0;
   int          m_wstart, m_wlen, m_wbeat;
   bit          m_wfix, m_werr;
   logic [1:0]  m_bresp = 2'b00;
   rbeat_t      rq[$];
   rbeat_t      mb;
   int          m_s, m_i;
   bit          m_f, m_e;
   bit          armed = 1'b0;

   function automatic bit oor(input logic [31:0] a);
`ifdef AXI_SRAM_RANGE_CHECK_EN
      return a >= 32'(DEPTH * 4);
`else
      return a != a;
`endif
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a / 32'd4) % 32'(DEPTH));
   endfunction

   always @(posedge aclk or negedge areset) armed <= areset;

   always @(negedge aclk) begin
      if (!areset) begin
         check("rst_ctl", {24'd0, awready, wready, bvalid, arready, rvalid, rlast, |bresp, |rresp}, 32'd0);
         check("rst_rdata", rdata, 32'd0);
         wph = 0;
         rph = 0;
         rq.delete();
      end else if (armed) begin
         check("awready", awready, 32'(wph == 0));
         check("wready", wready, 32'(wph == 1));
         check("bvalid", bvalid, 32'(wph == 2));
         if (wph == 2) check("bresp", bresp, m_bresp);
         check("arready", arready, 32'(rph == 0));
         check("rvalid", rvalid, 32'(rph == 1));
         if (rph == 1 && rq.size() > 0) begin
            check("rdata", rdata, rq[0].d);
            check("rresp", rresp, rq[0].r);
            check("rlast", rlast, rq[0].l);
         end
         // reads evaluated before writes: a same-edge write must not be visible
         if (rph == 0 && arvalid) begin
            m_s = word_of(araddr);
            m_e = oor(araddr);
            m_f = (arburst == 2'b00);
            for (int k = 0; k <= int'(arlen); k++) begin
               m_i  = (m_s + (m_f ? 0 : k)) % DEPTH;
               mb.d = m_e ? 32'd0 : m_mem[m_i];
               mb.r = m_e ? 2'b10 : 2'b00;
               mb.l = (k == int'(arlen));
               rq.push_back(mb);
            end
            rph = 1;
         end else if (rph == 1 && rready) begin
            void'(rq.pop_front());
            if (rq.size() == 0) rph = 0;
         end
         if (wph == 0 && awvalid) begin
            m_wstart = word_of(awaddr);
            m_wlen   = int'(awlen);
            m_wfix   = (awburst == 2'b00);
            m_werr   = oor(awaddr);
            m_wbeat  = 0;
            wph      = 1;
         end else if (wph == 1 && wvalid) begin
            if (!m_werr) begin
               m_i = (m_wstart + (m_wfix ? 0 : m_wbeat)) % DEPTH;
               for (int b = 0; b < 4; b++)
                  if (wstrb[b]) m_mem[m_i][8*b +: 8] = wdata[8*b +: 8];
            end
            m_wbeat++;
            if (m_wbeat > m_wlen) begin
               wph     = 2;
               m_bresp = m_werr ? 2'b10 : 2'b00;
            end
         end else if (wph == 2 && bready) begin
            wph = 0;
         end
      end
   end

   // ---------------- drivers ----------------
   logic [31:0] wd_q[$];
   logic [3:0]  ws_q[$];
   rbeat_t      got[$];
   logic [1:0]  resp;

   task automatic wait_rdy(input int ch, input string nm);
      int  t;
      bit  ok;
      t  = 0;
      ok = 1'b0;
      while (!ok) begin
         @(negedge aclk);
         ok = (ch == 0 && awready) || (ch == 1 && wready) || (ch == 2 && arready) || (ch == 3 && bvalid);
         t++;
         if (!ok && t > 200) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no handshake after %0d cycles, expected ready/valid high", nm, t);
            ok = 1'b1;
         end
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu,
                           input bit rnd, output logic [1:0] rsp);
      awaddr = a; awlen = len; awburst = bu; awsize = 3'($urandom); awvalid = 1'b1;
      wait_rdy(0, "aw_hs");
      @(posedge aclk); #1 awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
         wdata = wd_q[i]; wstrb = ws_q[i];
         wlast = rnd ? 1'($urandom) : (i == int'(len));
         wvalid = 1'b1;
         wait_rdy(1, "w_hs");
         @(posedge aclk); #1 wvalid = 1'b0;
      end
      wait_rdy(3, "b_wait");
      rsp = bresp;
      if (rnd) repeat ($urandom_range(0, 3)) begin @(posedge aclk); #1; end
      @(posedge aclk); #1 bready = 1'b1;
      @(posedge aclk); #1 bready = 1'b0;
   endtask

   // mode 0: rready always high, 1: toggles 1,0,1,0..., 2: random
   task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu, input int mode);
      int          t;
      bit          done, stalled;
      logic [31:0] sd;
      logic        sl;
      rbeat_t      b;
      got.delete();
      t = 0; done = 1'b0; stalled = 1'b0; sd = '0; sl = 1'b0;
      araddr = a; arlen = len; arburst = bu; arsize = 3'($urandom); arvalid = 1'b1;
      wait_rdy(2, "ar_hs");
      @(posedge aclk); #1 arvalid = 1'b0;
      rready = (mode == 2) ? 1'($urandom) : 1'b1;
      @(negedge aclk);
      check("r_first_lat", rvalid, 1);
      while (!done) begin
         if (stalled) begin
            check("r_stall_data", rdata, sd);
            check("r_stall_last", rlast, sl);
            stalled = 1'b0;
         end
         if (rvalid && rready) begin
            b.d = rdata; b.r = rresp; b.l = rlast;
            got.push_back(b);
            if (rlast) done = 1'b1;
         end else if (rvalid) begin
            stalled = 1'b1; sd = rdata; sl = rlast;
         end
         if (!done) begin
            t++;
            if (t > 600) begin
               n_vec++;
               n_err++;
               $display("FAIL r_burst: no rlast after %0d cycles, expected burst end", t);
               done = 1'b1;
            end else begin
               @(posedge aclk); #1;
               rready = (mode == 0) ? 1'b1 : (mode == 1) ? ~rready : 1'($urandom);
               @(negedge aclk);
            end
         end
      end
      @(posedge aclk); #1 rready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;
      repeat (3) @(posedge aclk);
      #1 areset = 1'b1;
      @(posedge aclk); #1;
      check("awready_after_rst", awready, 1);
      check("arready_after_rst", arready, 1);

      // fill the whole array so every later read has a known expectation
      for (int blk = 0; blk < DEPTH / 256; blk++) begin
         wd_q.delete(); ws_q.delete();
         for (int i = 0; i < 256; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'hF); end
         do_write(32'(blk * 1024), 8'd255, 2'b01, 1'b0, resp);
      end

      // single write / read
      wd_q = '{32'hDEADBEEF}; ws_q = '{4'hF};
      do_write(32'h10, 8'd0, 2'b01, 1'b0, resp);
      check("single_bresp", resp, 2'b00);
      do_read(32'h10, 8'd0, 2'b01, 0);
      check("single_cnt", got.size(), 1);
      check("single_rdata", got[0].d, 32'hDEADBEEF);
      check("single_rlast", got[0].l, 1);

      // partial write
      wd_q = '{32'hFFFFFFFF}; ws_q = '{4'hF};
      do_write(32'h20, 8'd0, 2'b01, 1'b0, resp);
      wd_q = '{32'h11223344}; ws_q = '{4'b0101};
      do_write(32'h20, 8'd0, 2'b01, 1'b0, resp);
      do_read(32'h20, 8'd0, 2'b01, 0);
      check("partial_rdata", got[0].d, 32'hFF22FF44);

      // INCR burst, read back under backpressure
      wd_q = '{32'd1, 32'd2, 32'd3, 32'd4}; ws_q = '{4'hF, 4'hF, 4'hF, 4'hF};
      do_write(32'h100, 8'd3, 2'b01, 1'b0, resp);
      do_read(32'h100, 8'd3, 2'b01, 1);
      check("incr_cnt", got.size(), 4);
      if (got.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check("incr_rdata", got[i].d, 32'(i + 1));
            check("incr_rlast", got[i].l, 32'(i == 3));
         end
      end

      // wrap at the top of memory
      wd_q = '{32'hAAAA0001, 32'hAAAA0002}; ws_q = '{4'hF, 4'hF};
      do_write(32'(DEPTH * 4 - 4), 8'd1, 2'b01, 1'b0, resp);
      do_read(32'h0, 8'd0, 2'b01, 0);
      check("wrap_idx0", got[0].d, 32'hAAAA0002);
      do_read(32'(DEPTH * 4 - 4), 8'd0, 2'b01, 0);
      check("wrap_top", got[0].d, 32'hAAAA0001);

      // same-cycle read and write of one word
      wd_q = '{32'h0BADF00D}; ws_q = '{4'hF};
      do_write(32'h40, 8'd0, 2'b01, 1'b0, resp);
      awaddr = 32'h40; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
      wait_rdy(0, "sim_aw");
      @(posedge aclk); #1 awvalid = 1'b0;
      wdata = 32'hC0FFEE00; wstrb = 4'hF; wvalid = 1'b1;
      araddr = 32'h40; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
      @(negedge aclk);
      check("sim_wready", wready, 1);
      check("sim_arready", arready, 1);
      @(posedge aclk); #1 wvalid = 1'b0; arvalid = 1'b0; rready = 1'b1;
      @(negedge aclk);
      check("sim_rvalid", rvalid, 1);
      check("sim_old_data", rdata, 32'h0BADF00D);
      @(posedge aclk); #1 rready = 1'b0;
      wait_rdy(3, "sim_b");
      @(posedge aclk); #1 bready = 1'b1;
      @(posedge aclk); #1 bready = 1'b0;
      do_read(32'h40, 8'd0, 2'b01, 0);
      check("sim_new_data", got[0].d, 32'hC0FFEE00);

      // reset in the middle of a write burst
      awaddr = 32'h200; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
      wait_rdy(0, "rst_aw");
      @(posedge aclk); #1 awvalid = 1'b0;
      wdata = 32'h5555AAAA; wstrb = 4'hF; wvalid = 1'b1;
      wait_rdy(1, "rst_w");
      @(posedge aclk); #1 wvalid = 1'b0; areset = 1'b0;
      repeat (3) @(posedge aclk);
      #1 areset = 1'b1;
      @(posedge aclk); #1;
      check("rst2_awready", awready, 1);
      check("rst2_arready", arready, 1);
      for (int i = 0; i < 6; i++) begin
         @(negedge aclk);
         check("rst2_no_bvalid", bvalid, 0);
      end
      @(posedge aclk); #1;
      do_read(32'h200, 8'd0, 2'b01, 0);
      check("rst2_beat0_kept", got[0].d, 32'h5555AAAA);
      do_read(32'h10, 8'd0, 2'b01, 0);
      check("rst2_mem_kept", got[0].d, 32'hDEADBEEF);

      // upper address bits
`ifdef AXI_SRAM_RANGE_CHECK_EN
      wd_q = '{32'h12345678}; ws_q = '{4'hF};
      do_write(32'h8000_0010, 8'd0, 2'b01, 1'b0, resp);
      check("oor_bresp", resp, 2'b10);
      do_read(32'h8000_0000, 8'd0, 2'b01, 0);
      check("oor_rresp", got[0].r, 2'b10);
      check("oor_rdata", got[0].d, 32'h0);
      do_read(32'h10, 8'd0, 2'b01, 0);
      check("oor_no_write", got[0].d, 32'hDEADBEEF);
`else
      do_read(32'h8000_0000, 8'd0, 2'b01, 0);
      check("alias_rresp", got[0].r, 2'b00);
      check("alias_rdata", got[0].d, 32'hAAAA0002);
`endif

      // randomized bursts, checked by the model
      for (int n = 0; n < 40; n++) begin
         logic [7:0] len;
         len = 8'($urandom_range(0, 7));
         a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) a = a | (32'($urandom) << (DL2 + 2));
         wd_q.delete(); ws_q.delete();
         for (int i = 0; i <= int'(len); i++) begin
            wd_q.push_back($urandom);
            ws_q.push_back(4'($urandom));
         end
         do_write(a, len, 2'($urandom), 1'b1, resp);
         if ($urandom_range(0, 1) == 0)
            a = (32'($urandom_range(0, DEPTH - 1)) << 2);
         do_read(a, 8'($urandom_range(0, 7)), 2'($urandom), 2);
      end

      repeat (4) @(posedge aclk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
